// File: rtl/seq_calc_core.sv
// Sequential calculator datapath: latches operands on start, then runs add/sub in one
// step or shift-add multiply / restoring divide one bit per cycle, flagging bad digits.
module seq_calc_core #(
  parameter int          DIGITS    = 2,
  parameter int          MAX_DIGIT = 11,
  parameter logic [15:0] UNDF_CODE = 16'h0123,
  localparam int         W         = 4 * DIGITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           neg,
  output logic [1:0]     err
);

  localparam int             CW   = $clog2(W) + 1;
  localparam logic [3:0]     MAXD = 4'(MAX_DIGIT);
  localparam logic [2*W-1:0] UNDF = (2*W)'(UNDF_CODE);

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIN = 2'b10} state_t;

  state_t           state_r;
  state_t           state_s;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic [2*W-1:0]   acc_r;
  logic [2*W-1:0]   mcand_r;
  logic [W-1:0]     mplier_r;
  logic [W-1:0]     rem_r;
  logic [W-1:0]     quot_r;

  logic             invalid_s;
  logic             div_zero_s;
  logic             long_op_s;
  logic             last_s;
  logic [W:0]       div_sh_s;
  logic [W:0]       div_diff_s;
  logic             div_ge_s;
  logic [2*W-1:0]   fin_result_s;
  logic [W-1:0]     fin_rem_s;
  logic             fin_neg_s;
  logic [1:0]       fin_err_s;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > MAXD);
    end
    return bad;
  endfunction

  // Error classification and per-op cycle budget from the latched operands
  always_comb begin
    invalid_s  = has_bad_digit(a_r) | has_bad_digit(b_r);
    div_zero_s = !invalid_s && (op_r == 2'b11) && (b_r == {W{1'b0}});
    long_op_s  = !invalid_s && !div_zero_s && op_r[1];
    if (long_op_s) begin
      last_s = (cnt_r == CW'(W - 1));
    end else begin
      last_s = 1'b1;
    end
  end

  // One restoring-division step: bring down the next dividend bit and trial-subtract
  always_comb begin
    div_sh_s   = {rem_r, quot_r[W-1]};
    div_ge_s   = (div_sh_s >= {1'b0, b_r});
    div_diff_s = div_sh_s - {1'b0, b_r};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = FIN;
        end else begin
          state_s = CALC;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Final result selection; invalid digits take priority over divide-by-zero
  always_comb begin
    fin_result_s = {(2*W){1'b0}};
    fin_rem_s    = {W{1'b0}};
    fin_neg_s    = 1'b0;
    fin_err_s    = 2'b00;
    if (invalid_s) begin
      fin_err_s    = 2'b01;
      fin_result_s = UNDF;
    end else if (div_zero_s) begin
      fin_err_s    = 2'b10;
    end else begin
      case (op_r)
        2'b00: fin_result_s = {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
        2'b01: begin
          if (a_r >= b_r) begin
            fin_result_s = {{W{1'b0}}, a_r - b_r};
          end else begin
            fin_result_s = {{W{1'b0}}, b_r - a_r};
            fin_neg_s    = 1'b1;
          end
        end
        2'b10: fin_result_s = acc_r;
        2'b11: begin
          fin_result_s = {{W{1'b0}}, quot_r};
          fin_rem_s    = rem_r;
        end
        default: fin_result_s = {(2*W){1'b0}};
      endcase
    end
  end

  // Operand latch and iterative multiply/divide datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      op_r     <= 2'b00;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      rem_r    <= {W{1'b0}};
      quot_r   <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            mcand_r  <= {{W{1'b0}}, a};
            mplier_r <= b;
            rem_r    <= {W{1'b0}};
            quot_r   <= a;
          end else begin
            cnt_r    <= cnt_r;
          end
        end
        CALC: begin
          cnt_r <= cnt_r + CW'(1);
          if (op_r == 2'b10) begin
            if (mplier_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end else begin
              acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
          end else if (op_r == 2'b11) begin
            rem_r  <= div_ge_s ? div_diff_s[W-1:0] : div_sh_s[W-1:0];
            quot_r <= {quot_r[W-2:0], div_ge_s};
          end else begin
            acc_r <= acc_r;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Registered outputs; busy stays high through the done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= {(2*W){1'b0}};
      remainder <= {W{1'b0}};
      neg       <= 1'b0;
      err       <= 2'b00;
    end else begin
      done <= (state_r == FIN);
      if (state_r == IDLE) begin
        busy <= start;
      end else begin
        busy <= 1'b1;
      end
      if (state_r == FIN) begin
        result    <= fin_result_s;
        remainder <= fin_rem_s;
        neg       <= fin_neg_s;
        err       <= fin_err_s;
      end else begin
        result    <= result;
      end
    end
  end

endmodule

// File: tb/tb_seq_calc_core.sv
// Randomized self-checking bench for seq_calc_core against an arithmetic reference model.
module tb_seq_calc_core;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           neg;
  logic [1:0]     err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_calc_core dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .remainder(remainder),
    .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int res;
    int rem;
    int ng;
    int er;
    int lat;
  } exp_t;

  function automatic exp_t model(input int o, input int av, input int bv);
    exp_t e;
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < W / 4; i++) begin
      if (((av >> (4 * i)) & 15) > 11 || ((bv >> (4 * i)) & 15) > 11) bad = 1'b1;
    end
    e.res = 0; e.rem = 0; e.ng = 0; e.er = 0; e.lat = 2;
    if (bad) begin
      e.er = 1; e.res = 'h0123;
    end else if (o == 3 && bv == 0) begin
      e.er = 2;
    end else begin
      case (o)
        0: e.res = av + bv;
        1: begin
          if (av >= bv) e.res = av - bv;
          else begin e.res = bv - av; e.ng = 1; end
        end
        2: begin e.res = av * bv; e.lat = W + 1; end
        default: begin e.res = av / bv; e.rem = av % bv; e.lat = W + 1; end
      endcase
    end
    return e;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit hold_start);
    exp_t e;
    int n;
    bit got;
    e = model(int'(o), int'(av), int'(bv));
    @(negedge clk);
    a = av; b = bv; op = o; start = 1'b1;
    @(posedge clk); #1;
    check_eq("busy_after_start", busy, 1);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (n == 0) begin
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        start = hold_start;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
      else if (!busy) begin
        check_eq("busy_during_op", busy, 1);
      end
    end
    check_eq("latency", n, e.lat);
    check_eq("busy_at_done", busy, 1);
    check_eq("result", result, e.res);
    check_eq("remainder", remainder, e.rem);
    check_eq("neg", neg, e.ng);
    check_eq("err", err, e.er);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("no_extra_done", done, 0);
      check_eq("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    bit           saw_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_result", result, 0);
    check_eq("reset_err", err, 0);
    @(negedge clk); rst = 1'b0;

    run_op(2'b00, 8'hBB, 8'h01, 1'b0);
    run_op(2'b01, 8'h05, 8'h12, 1'b0);
    run_op(2'b10, 8'h12, 8'h05, 1'b0);
    run_op(2'b11, 8'hB0, 8'h0B, 1'b0);
    run_op(2'b11, 8'hB0, 8'h00, 1'b0);
    run_op(2'b10, 8'hC1, 8'h01, 1'b1);
    run_op(2'b11, 8'h01, 8'hC1, 1'b1);
    run_op(2'b01, 8'h12, 8'h05, 1'b0);
    run_op(2'b11, 8'hBB, 8'h07, 1'b1);

    // Reset in the middle of a multiply must abort with no done pulse
    @(negedge clk);
    a = 8'h12; b = 8'h05; op = 2'b10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk); rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_neg", neg, 0);
    check_eq("rst_err", err, 0);
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_eq("rst_no_done", saw_done, 0);

    for (int t = 0; t < 40; t++) begin
      ro = 2'($urandom);
      for (int i = 0; i < W / 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 11));
        rb[4*i +: 4] = 4'($urandom_range(0, 11));
      end
      if ($urandom_range(0, 7) == 0) ra = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = W'($urandom);
      if (ro == 2'b11 && $urandom_range(0, 5) == 0) rb = '0;
      run_op(ro, ra, rb, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
